// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP payload RAM write arbiter.
//   state_e           : arbiter FSM states
//   UDP_HDR           : UDP header bytes added to the payload length
//   IPUDP_HDR         : IP + UDP header bytes added to the payload length
//   DEF_PAYLOAD_BYTES : payload size reported before any frame is built
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_WAIT_TX = 2'd2
  } state_e;

  localparam int unsigned UDP_HDR           = 8;
  localparam int unsigned IPUDP_HDR         = 28;
  localparam int unsigned DEF_PAYLOAD_BYTES = 20;

  function automatic logic [15:0] add_hdr(input logic [15:0] bytes, input int unsigned hdr);
    return bytes + 16'(hdr);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick used by the payload arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_i      : {req1, req0}
//   advance_i  : a burst is starting with the current pick
//   pick_o     : one-hot (or zero) winner, combinational from req_i
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] pick_o
);

  // Reset to "requester 1 went last" so requester 0 is preferred first.
  logic last_grant_q, last_grant_d;

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) pick_o = last_grant_q ? 2'b01 : 2'b10;
    last_grant_d = last_grant_q;
    if (advance_i && (pick_o != 2'b00)) last_grant_d = pick_o[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/udp_payload_arbiter.sv
// Arbitrates the payload RAM write port between the echo path (0) and the
// local loader (1), publishes the frame lengths after a completed burst and
// holds the RAM locked until the transmit engine reports the frame sent.
//   clk, rst_n                     : gmii_rx_clk domain, async active-low reset
//   reqN / wrN_*                   : requester N burst request and word strobe
//   gnt0 / gnt1                    : registered grants, one-hot or zero
//   ram_wea / ram_addra / ram_dina : registered RAM write port
//   frame_ready                    : frame waiting for the transmit engine
//   tx_data_length/tx_total_length : UDP length / IP total length
//   tx_done                        : frame sent pulse from transmit engine
//   err                            : pulse on timeout or overflow abort
//
// state      | meaning
// ST_IDLE    | no owner; arbitrate pending requests
// ST_BURST   | granted requester owns the RAM write port
// ST_WAIT_TX | frame published; RAM locked until tx_done
module udp_payload_arbiter
  import udp_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0_valid,
  input  logic              wr1_valid,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr0_last,
  input  logic              wr1_last,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              frame_ready,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  input  logic              tx_done,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]       DEF_DLEN = 16'(DEF_PAYLOAD_BYTES + UDP_HDR);
  localparam logic [15:0]       DEF_TLEN = 16'(DEF_PAYLOAD_BYTES + IPUDP_HDR);

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                fr_q, fr_d;
  logic [15:0]         dlen_q, dlen_d;
  logic [15:0]         tlen_q, tlen_d;
  logic                err_q, err_d;

  logic [1:0]          pick;
  logic                arb_adv;
  logic                sel_req, sel_valid, sel_last;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [15:0]         bytes;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({req1, req0}),
    .advance_i (arb_adv),
    .pick_o    (pick)
  );

  // Only the owner's strobes reach the RAM; the other side is ignored.
  assign sel_req   = gnt_q[1] ? req1      : req0;
  assign sel_valid = gnt_q[1] ? wr1_valid : wr0_valid;
  assign sel_last  = gnt_q[1] ? wr1_last  : wr0_last;
  assign sel_addr  = gnt_q[1] ? wr1_addr  : wr0_addr;
  assign sel_data  = gnt_q[1] ? wr1_data  : wr0_data;
  assign bytes     = 16'({cnt_q, 2'b00});

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    wea_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    fr_d    = fr_q;
    dlen_d  = dlen_q;
    tlen_d  = tlen_q;
    err_d   = 1'b0;
    arb_adv = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmr_d = TMR_LOAD;
        if (pick != 2'b00) begin
          gnt_d   = pick;
          arb_adv = 1'b1;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        // A valid word reloads the idle timer, so last always beats expiry.
        if (sel_valid) begin
          tmr_d = TMR_LOAD;
          if (cnt_q == CNT_MAX) begin
            err_d   = 1'b1;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end else begin
            wea_d  = 1'b1;
            addr_d = sel_addr;
            din_d  = sel_data;
            cnt_d  = cnt_q + CNT_ONE;
            if (sel_last) begin
              gnt_d   = 2'b00;
              state_d = ST_WAIT_TX;
            end
          end
        end else if (!sel_req) begin
          // Requester withdrew without a last word: no frame, no error.
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      ST_WAIT_TX: begin
        if (!fr_q) begin
          fr_d   = 1'b1;
          dlen_d = add_hdr(bytes, UDP_HDR);
          tlen_d = add_hdr(bytes, IPUDP_HDR);
        end
        if (tx_done) begin
          fr_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      tmr_q   <= TMR_LOAD;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      fr_q    <= 1'b0;
      dlen_q  <= DEF_DLEN;
      tlen_q  <= DEF_TLEN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      fr_q    <= fr_d;
      dlen_q  <= dlen_d;
      tlen_q  <= tlen_d;
      err_q   <= err_d;
    end
  end

  assign gnt0            = gnt_q[0];
  assign gnt1            = gnt_q[1];
  assign ram_wea         = wea_q;
  assign ram_addra       = addr_q;
  assign ram_dina        = din_q;
  assign frame_ready     = fr_q;
  assign tx_data_length  = dlen_q;
  assign tx_total_length = tlen_q;
  assign err             = err_q;

endmodule

// File: tb/tb_udp_payload_arbiter.sv
// Directed bench for udp_payload_arbiter (TIMEOUT overridden to 16).
module tb_udp_payload_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0_valid, wr1_valid, wr0_last, wr1_last;
  logic [8:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        gnt0, gnt1, ram_wea, frame_ready, tx_done, err;
  logic [8:0]  ram_addra;
  logic [31:0] ram_dina;
  logic [15:0] tx_data_length, tx_total_length;

  int n_tests = 0;
  int n_fail  = 0;
  int poison_cnt = 0;

  always #5 clk = ~clk;

  udp_payload_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .wr0_valid(wr0_valid), .wr1_valid(wr1_valid),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr0_last(wr0_last), .wr1_last(wr1_last),
    .gnt0(gnt0), .gnt1(gnt1),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .frame_ready(frame_ready),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .tx_done(tx_done), .err(err)
  );

  always @(negedge clk)
    if (ram_wea && ram_dina == 32'hDEADBEEF) poison_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req0 = 0; req1 = 0; wr0_valid = 0; wr1_valid = 0; wr0_last = 0; wr1_last = 0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0; tx_done = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    #12;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_fr", frame_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_dlen", tx_data_length, 28);
    chk("rst_tlen", tx_total_length, 48);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Drive n words from requester `who` (already granted). With poison set,
  // the other requester strobes 0xDEADBEEF on alternate cycles.
  // With use_last, the final word carries last.
  task automatic burst(input int who, input int n, input logic use_last, input logic poison);
    logic [31:0] d;
    logic [8:0]  a;
    logic        l;
    for (int i = 0; i < n; i++) begin
      d = (32'(who + 1) << 28) | 32'(i);
      a = 9'(i + 1);
      l = use_last && (i == n - 1);
      if (who == 0) begin
        wr0_valid = 1; wr0_addr = a; wr0_data = d; wr0_last = l;
        if (poison) begin wr1_valid = (i % 2 == 0); wr1_addr = a; wr1_data = 32'hDEADBEEF; wr1_last = 1; end
      end else begin
        wr1_valid = 1; wr1_addr = a; wr1_data = d; wr1_last = l;
      end
      tick();
      chk("wr_wea", ram_wea, 1);
      chk("wr_addr", ram_addra, a);
      chk("wr_data", ram_dina, d);
    end
    wr0_valid = 0; wr1_valid = 0; wr0_last = 0; wr1_last = 0;
  endtask

  initial begin
    int cyc;
    int nwr;
    rst_n = 0;
    clr_inputs();

    // Single burst from the loader
    do_reset();
    req1 = 1;
    tick();
    chk("s_gnt", {30'd0, gnt1, gnt0}, 32'b10);
    burst(1, 5, 1, 0);
    req1 = 0;
    chk("s_gnt_drop", {30'd0, gnt1, gnt0}, 32'd0);
    chk("s_fr_early", frame_ready, 0);
    tick();
    chk("s_fr", frame_ready, 1);
    chk("s_wea_off", ram_wea, 0);
    chk("s_dlen", tx_data_length, 28);
    chk("s_tlen", tx_total_length, 48);
    tx_done = 1;
    tick();
    tx_done = 0;
    chk("s_fr_clr", frame_ready, 0);

    // Contention after reset, plus isolation of requester 1 strobes
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    chk("c_gnt_first", {30'd0, gnt1, gnt0}, 32'b01);
    burst(0, 3, 1, 1);
    tick();
    chk("c_fr", frame_ready, 1);
    chk("c_dlen", tx_data_length, 20);
    chk("c_tlen", tx_total_length, 40);
    chk("iso_poison", poison_cnt, 0);
    tick();
    chk("c_lock", {30'd0, gnt1, gnt0}, 32'd0);
    tx_done = 1;
    tick();
    tx_done = 0;
    chk("c_b2b_nogrant", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk("c_gnt_second", {30'd0, gnt1, gnt0}, 32'b10);
    burst(1, 2, 1, 0);
    tick();
    chk("c_dlen2", tx_data_length, 16);
    tx_done = 1;
    tick();
    tx_done = 0;
    tick();
    chk("c_gnt_third", {30'd0, gnt1, gnt0}, 32'b01);
    req0 = 0; req1 = 0;
    tick();
    chk("zw_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("zw_err", err, 0);
    tick();
    chk("zw_fr", frame_ready, 0);

    // Timeout: 16 idle cycles inside a granted burst
    do_reset();
    req0 = 1;
    tick();
    chk("t_gnt", gnt0, 1);
    cyc = 0;
    while (!err && cyc < 40) begin
      tick();
      cyc++;
    end
    req0 = 0;
    chk("t_err_seen", err, 1);
    chk("t_cycles", cyc, 16);
    chk("t_gnt_drop", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk("t_err_pulse", err, 0);
    chk("t_fr", frame_ready, 0);

    // Overflow: 513 words without last
    do_reset();
    req1 = 1;
    tick();
    chk("o_gnt", gnt1, 1);
    nwr = 0;
    for (int i = 0; i < 513; i++) begin
      wr1_valid = 1; wr1_addr = 9'(i); wr1_data = 32'h5500_0000 | 32'(i);
      tick();
      if (i < 512 && ram_wea) nwr++;
    end
    wr1_valid = 0; req1 = 0;
    chk("o_writes", nwr, 512);
    chk("o_513_dropped", ram_wea, 0);
    chk("o_err", err, 1);
    chk("o_gnt_drop", gnt1, 0);
    tick();
    chk("o_fr", frame_ready, 0);

    // Full 512-word frame
    req0 = 1;
    tick();
    chk("f_gnt", gnt0, 1);
    burst(0, 512, 1, 0);
    req0 = 0;
    tick();
    chk("f_fr", frame_ready, 1);
    chk("f_dlen", tx_data_length, 2056);
    chk("f_tlen", tx_total_length, 2076);

    // Asynchronous reset while frame is waiting
    #2 rst_n = 0;
    #1;
    chk("r_fr", frame_ready, 0);
    chk("r_dlen", tx_data_length, 28);
    chk("r_tlen", tx_total_length, 48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
